// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - HH:MM:SS timekeeping and keypad time-set controller
//
// Counts time in RUN. In SET_H/SET_M/SET_S the selected field is adjusted
// by key_inc/key_dec, and the display receives a blink strobe for that field.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   key_sel_h/m/s             pulse: enter SET_H / SET_M / SET_S
//   key_inc, key_dec          pulse: adjust the selected field (ignored in RUN)
//   key_run                   pulse: return to RUN, prescaler restarts
//   key_preset                pulse: load INIT_* time and return to RUN
//   hou, min, sec             current time
//   sel                       {h,m,s} one-hot selected field, 000 in RUN
//   stop_clk                  1 while in any set state
//   blink                     blank strobe for the selected field, 0 in RUN
//   tick_1hz                  one-cycle pulse with each counted second
module time_set_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_DIV = 12_500_000,
  parameter int INIT_HOU  = 12,
  parameter int INIT_MIN  = 46,
  parameter int INIT_SEC  = 57
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_sel_h,
  input  logic       key_sel_m,
  input  logic       key_sel_s,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_run,
  input  logic       key_preset,
  output logic [5:0] hou,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [2:0] sel,
  output logic       stop_clk,
  output logic       blink,
  output logic       tick_1hz
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLK_TC = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

  state_t        state, state_nxt;
  logic          state_key;
  logic          adj_up, adj_dn;
  logic [2:0]    sel_nxt;
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] maxv);
    return (v == maxv) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_wrap(input logic [5:0] v, input logic [5:0] maxv);
    return (v == 6'd0) ? maxv : v - 6'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Any state-changing key consumes the cycle: inc/dec and the tick are dropped.
  always_comb begin
    state_nxt = state;
    state_key = 1'b0;
    sel_nxt   = 3'b000;
    if (key_preset || key_run) begin
      state_nxt = RUN;
      state_key = 1'b1;
    end else if (key_sel_h) begin
      state_nxt = SET_H;
      state_key = 1'b1;
    end else if (key_sel_m) begin
      state_nxt = SET_M;
      state_key = 1'b1;
    end else if (key_sel_s) begin
      state_nxt = SET_S;
      state_key = 1'b1;
    end
    adj_up = (state != RUN) && !state_key && key_inc && !key_dec;
    adj_dn = (state != RUN) && !state_key && key_dec && !key_inc;
    case (state_nxt)
      SET_H:   sel_nxt = 3'b100;
      SET_M:   sel_nxt = 3'b010;
      SET_S:   sel_nxt = 3'b001;
      default: sel_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hou      <= 6'(INIT_HOU);
      min      <= 6'(INIT_MIN);
      sec      <= 6'(INIT_SEC);
      presc    <= '0;
      tick_1hz <= 1'b0;
      sel      <= 3'b000;
      stop_clk <= 1'b0;
    end else begin
      sel      <= sel_nxt;
      stop_clk <= (state_nxt != RUN);
      tick_1hz <= 1'b0;
      if (key_preset) begin
        hou   <= 6'(INIT_HOU);
        min   <= 6'(INIT_MIN);
        sec   <= 6'(INIT_SEC);
        presc <= '0;
      end else if (state_key) begin
        presc <= '0;
      end else if (state == RUN) begin
        if (presc == PRE_TC) begin
          presc    <= '0;
          tick_1hz <= 1'b1;
          sec      <= inc_wrap(sec, 6'd59);
          if (sec == 6'd59) begin
            min <= inc_wrap(min, 6'd59);
            if (min == 6'd59) hou <= inc_wrap(hou, 6'd23);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end else begin
        presc <= '0;
        if (adj_up || adj_dn) begin
          case (state)
            SET_H:   hou <= adj_up ? inc_wrap(hou, 6'd23) : dec_wrap(hou, 6'd23);
            SET_M:   min <= adj_up ? inc_wrap(min, 6'd59) : dec_wrap(min, 6'd59);
            SET_S:   sec <= adj_up ? inc_wrap(sec, 6'd59) : dec_wrap(sec, 6'd59);
            default: ;
          endcase
        end
      end
    end
  end

  // Blink phase restarts (visible) each time a field is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= 1'b0;
      bcnt  <= '0;
    end else if (state_nxt == RUN) begin
      blink <= 1'b0;
      bcnt  <= '0;
    end else if (state_key) begin
      blink <= 1'b1;
      bcnt  <= '0;
    end else if (bcnt == BLK_TC) begin
      blink <= ~blink;
      bcnt  <= '0;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
module tb_time_set_ctrl;
  localparam int CLK_HZ    = 10;
  localparam int BLINK_DIV = 4;
  localparam int INIT_T    = 12*3600 + 46*60 + 57;

  localparam logic [6:0] K_PRE = 7'b1000000;
  localparam logic [6:0] K_RUN = 7'b0100000;
  localparam logic [6:0] K_SH  = 7'b0010000;
  localparam logic [6:0] K_SM  = 7'b0001000;
  localparam logic [6:0] K_SS  = 7'b0000100;
  localparam logic [6:0] K_INC = 7'b0000010;
  localparam logic [6:0] K_DEC = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_sel_h = 1'b0, key_sel_m = 1'b0, key_sel_s = 1'b0;
  logic       key_inc = 1'b0, key_dec = 1'b0, key_run = 1'b0, key_preset = 1'b0;
  logic [5:0] hou, min, sec;
  logic [2:0] sel;
  logic       stop_clk, blink, tick_1hz;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_total = 0;

  // Model: time as seconds-of-day, mode 0=RUN 1=H 2=M 3=S, cycles since mode entry.
  bit m_valid = 1'b0;
  int m_mode = 0;
  int m_t = 0;
  int m_run = 0;
  int m_set = 0;
  bit m_tick = 1'b0;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV),
    .INIT_HOU(12), .INIT_MIN(46), .INIT_SEC(57)
  ) dut (
    .clk(clk), .rst(rst),
    .key_sel_h(key_sel_h), .key_sel_m(key_sel_m), .key_sel_s(key_sel_s),
    .key_inc(key_inc), .key_dec(key_dec), .key_run(key_run), .key_preset(key_preset),
    .hou(hou), .min(min), .sec(sec), .sel(sel),
    .stop_clk(stop_clk), .blink(blink), .tick_1hz(tick_1hz)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_adjust(input int d);
    int h, mi, s;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    case (m_mode)
      1: h  = (h + 24 + d) % 24;
      2: mi = (mi + 60 + d) % 60;
      3: s  = (s + 60 + d) % 60;
      default: ;
    endcase
    m_t = h*3600 + mi*60 + s;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_mode = 0; m_t = INIT_T; m_run = 0; m_set = 0; m_tick = 1'b0;
    end else if (m_valid) begin
      m_tick = 1'b0;
      if (key_preset) begin
        m_mode = 0; m_t = INIT_T; m_run = 0;
      end else if (key_run) begin
        m_mode = 0; m_run = 0;
      end else if (key_sel_h) begin
        m_mode = 1; m_set = 0;
      end else if (key_sel_m) begin
        m_mode = 2; m_set = 0;
      end else if (key_sel_s) begin
        m_mode = 3; m_set = 0;
      end else if (m_mode == 0) begin
        m_run++;
        if (m_run % CLK_HZ == 0) begin
          m_t = (m_t + 1) % 86400;
          m_tick = 1'b1;
        end
      end else begin
        m_set++;
        if (key_inc != key_dec) model_adjust(key_inc ? 1 : -1);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      if (tick_1hz) tick_total++;
      chk("hou", hou, m_t / 3600);
      chk("min", min, (m_t / 60) % 60);
      chk("sec", sec, m_t % 60);
      chk("sel", sel, (m_mode == 1) ? 4 : (m_mode == 2) ? 2 : (m_mode == 3) ? 1 : 0);
      chk("stop_clk", stop_clk, (m_mode != 0) ? 1 : 0);
      chk("blink", blink, ((m_mode != 0) && ((m_set / BLINK_DIV) % 2 == 0)) ? 1 : 0);
      chk("tick_1hz", tick_1hz, m_tick);
    end
  end

  task automatic press(input logic [6:0] k, input logic r);
    {key_preset, key_run, key_sel_h, key_sel_m, key_sel_s, key_inc, key_dec} = k;
    rst = r;
    @(posedge clk);
    #2;
    {key_preset, key_run, key_sel_h, key_sel_m, key_sel_s, key_inc, key_dec} = 7'b0;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) press(7'b0, 1'b0);
  endtask

  task automatic set_to(input logic [6:0] selk, input int field, input int val);
    int g;
    press(selk, 1'b0);
    g = 0;
    while (((field == 0) ? m_t / 3600 : (field == 1) ? (m_t / 60) % 60 : m_t % 60) != val && g < 70) begin
      press(K_INC, 1'b0);
      g++;
    end
    chk("set_to_bound", (g < 70) ? 1 : 0, 1);
  endtask

  initial begin
    int t0, n;
    logic [6:0] k;
    logic r;

    press(7'b0, 1'b1);
    press(7'b0, 1'b1);
    chk("rst_hou", hou, 12); chk("rst_min", min, 46); chk("rst_sec", sec, 57);
    chk("rst_sel", sel, 0); chk("rst_stop", stop_clk, 0); chk("rst_blink", blink, 0);
    chk("rst_tick", tick_1hz, 0);
    t0 = tick_total;
    idle(30);
    chk("run30_sec", sec, 0); chk("run30_min", min, 47); chk("run30_hou", hou, 12);
    idle(1);
    chk("run30_ticks", tick_total - t0, 3);

    set_to(K_SH, 0, 23);
    set_to(K_SM, 1, 59);
    set_to(K_SS, 2, 59);
    chk("pre_roll_hou", hou, 23); chk("pre_roll_min", min, 59); chk("pre_roll_sec", sec, 59);
    press(K_RUN, 1'b0);
    idle(9);
    chk("roll_wait_sec", sec, 59); chk("roll_wait_tick", tick_1hz, 0);
    t0 = tick_total;
    idle(1);
    chk("roll_hou", hou, 0); chk("roll_min", min, 0); chk("roll_sec", sec, 0);
    chk("roll_tick", tick_1hz, 1);
    idle(1);
    chk("roll_ticks", tick_total - t0, 1);

    press(K_SH, 1'b0);
    chk("wrap_sel_h", sel, 3'b100); chk("wrap_stop", stop_clk, 1);
    press(K_DEC, 1'b0); chk("wrap_hdec", hou, 23);
    press(K_INC, 1'b0); chk("wrap_hinc", hou, 0);
    press(K_SM, 1'b0); chk("wrap_sel_m", sel, 3'b010);
    press(K_DEC, 1'b0); chk("wrap_mdec", min, 59); chk("wrap_sec", sec, 0);

    press(K_SM | K_INC, 1'b0);
    chk("prio_sel", sel, 3'b010); chk("prio_min", min, 59);
    press(K_INC | K_DEC, 1'b0); chk("incdec_min", min, 59);
    press(K_PRE | K_SH, 1'b0);
    chk("preset_hou", hou, 12); chk("preset_min", min, 46); chk("preset_sec", sec, 57);
    chk("preset_sel", sel, 0); chk("preset_stop", stop_clk, 0);

    press(K_SS, 1'b0);
    chk("blink_entry", blink, 1); chk("blink_sel", sel, 3'b001);
    for (int i = 1; i < 12; i++) begin
      idle(1);
      chk("blink_phase", blink, ((i / 4) % 2 == 0) ? 1 : 0);
    end
    press(K_RUN, 1'b0);
    chk("blink_run", blink, 0);
    n = 0;
    while (!tick_1hz && n < 20) begin
      idle(1);
      n++;
    end
    chk("first_tick_latency", n, CLK_HZ);

    press(K_SH, 1'b0);
    n = 0;
    while (m_t / 3600 != 5 && n < 30) begin
      press(K_DEC, 1'b0);
      n++;
    end
    chk("mid_hou", hou, 5);
    press(K_INC, 1'b1);
    chk("mid_rst_hou", hou, 12); chk("mid_rst_min", min, 46); chk("mid_rst_sec", sec, 57);
    chk("mid_rst_sel", sel, 0); chk("mid_rst_stop", stop_clk, 0);

    for (int i = 0; i < 3000; i++) begin
      k = 7'b0;
      if ($urandom_range(0, 99) == 0) k |= K_PRE;
      if ($urandom_range(0, 39) == 0) k |= K_RUN;
      if ($urandom_range(0, 29) == 0) k |= K_SH;
      if ($urandom_range(0, 29) == 0) k |= K_SM;
      if ($urandom_range(0, 29) == 0) k |= K_SS;
      if ($urandom_range(0, 3) == 0)  k |= K_INC;
      if ($urandom_range(0, 4) == 0)  k |= K_DEC;
      r = ($urandom_range(0, 499) == 0);
      press(k, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Timekeeping and time-set controller for the keypad digital clock. Consumes one-cycle key-event pulses from the matrix keypad scanner, sequences the HH:MM:SS counters between free-running and manual-adjust modes, and drives the display with the current time plus a blink strobe for the selected field. It replaces ad-hoc time adjustment in the scanner; the scanner only reports key events.

## Interface
- CLK_HZ, 50_000_000, input clock cycles per second (prescaler terminal count = CLK_HZ-1)
- BLINK_DIV, 12_500_000, cycles per blink phase in set modes
- INIT_HOU, 12, preset/reset hour (0..23)
- INIT_MIN, 46, preset/reset minute (0..59)
- INIT_SEC, 57, preset/reset second (0..59)

- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- key_sel_h  in  1  pulse: select hour field for adjust
- key_sel_m  in  1  pulse: select minute field
- key_sel_s  in  1  pulse: select second field
- key_inc  in  1  pulse: increment selected field
- key_dec  in  1  pulse: decrement selected field
- key_run  in  1  pulse: leave set mode, resume counting
- key_preset  in  1  pulse: load INIT_* values, resume counting
- hou  out  6  current hour, 0..23
- min  out  6  current minute, 0..59
- sec  out  6  current second, 0..59
- sel  out  3  {h,m,s} one-hot selected field; 000 in RUN
- stop_clk  out  1  1 while in any set state
- blink  out  1  display blank strobe for selected field; 0 in RUN
- tick_1hz  out  1  one-cycle pulse on each counted second

## Operation
- States: RUN, SET_H, SET_M, SET_S. All outputs registered.
- Transitions: key_sel_h/m/s from any state -> SET_H/SET_M/SET_S; key_run from any state -> RUN; key_preset from any state -> RUN with hou/min/sec <= INIT_*.
- Same-cycle priority: preset > run > sel_h > sel_m > sel_s > inc/dec. A state-changing key consumes the cycle; inc/dec that cycle are ignored. key_inc and key_dec together: no change.
- RUN: prescaler counts 0..CLK_HZ-1; at CLK_HZ-1 it wraps to 0, tick_1hz=1 next cycle, sec increments. Carry chain: sec 59->0 with min+1; min 59->0 with hou+1; hou 23->0. 23:59:59 -> 00:00:00 in one tick.
- RUN: key_inc/key_dec ignored.
- SET_x: prescaler held at 0, no ticks. key_inc: field+1, wrap at max (hou 23->0, min/sec 59->0). key_dec: field-1, wrap 0->23 (hou) or 0->59 (min/sec). No carry into other fields during adjust.
- Blink: counter 0..BLINK_DIV-1 toggles blink at terminal count while in SET_x; entering any SET_x from RUN or another SET_x clears counter and sets blink=1. In RUN blink=0 and counter held at 0.
- Leaving set mode (run/preset): prescaler restarts at 0; first increment occurs CLK_HZ cycles later.
- Out-of-range values cannot occur; all arithmetic in 6 bits with explicit compare-and-wrap, no modulo on underflow.

## Timing
- Reset (rst sampled high): hou=INIT_HOU, min=INIT_MIN, sec=INIT_SEC, state RUN, sel=000, stop_clk=0, blink=0, tick_1hz=0, prescaler=0, blink counter=0. Reset overrides all keys in the same cycle, including mid-adjust.
- Key pulse sampled at edge N -> state, sel, stop_clk, and field value updated at edge N+1 (1-cycle latency).
- Keys are assumed single-cycle; a key held high for k cycles acts as k events (inc/dec applied k times).
- tick_1hz is high for exactly one cycle, coincident with the updated sec value.
- A key_sel arriving on the same edge as prescaler terminal count: the state change wins and the tick is discarded.

## Test plan
- Reset with CLK_HZ=10: after rst, hou/min/sec=12/46/57, sel=000, stop_clk=0; after 30 cycles sec=0, min=47, and tick_1hz pulsed 3 times.
- Rollover: preset override to 23:59:59 via set keys, key_run, wait CLK_HZ cycles -> 00:00:00, single tick_1hz.
- Set wrap: key_sel_h then key_dec at hou=0 -> 23; key_inc -> 0; key_sel_m, key_dec at min=0 -> 59; sel=100 then 010, stop_clk=1, sec unchanged throughout.
- Priority: key_sel_m and key_inc in the same cycle -> state SET_M, min unchanged; key_inc+key_dec together -> no change; key_preset+key_sel_h -> RUN at 12:46:57.
- Blink with BLINK_DIV=4: in SET_S, blink=1 on entry and toggles every 4 cycles; after key_run, blink=0 and the first tick arrives exactly CLK_HZ cycles later.
- Reset mid-adjust: in SET_H with hou=5, assert rst together with key_inc -> 12:46:57, RUN, sel=000.
